// File: rtl/fpu_queue_dispatcher.sv
// Consumer end of the FPU instruction queue: pops one entry at a time, hands it to the NEU
// with a start/done handshake, and flushes the queue after FINIT/FLDCW, exceptions and timeouts.
module fpu_queue_dispatcher #(
    parameter logic [7:0]  OPC_FINIT      = 8'hF0,
    parameter logic [7:0]  OPC_FLDCW      = 8'hF1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        queue_empty,
    input  logic [7:0]  instruction_in,
    input  logic [2:0]  stack_index_in,
    input  logic        has_memory_op_in,
    input  logic [1:0]  operand_size_in,
    input  logic        is_integer_in,
    input  logic        is_bcd_in,
    input  logic [79:0] data_in,
    output logic        dequeue,
    output logic        flush_queue,
    output logic        neu_start,
    output logic [7:0]  neu_instruction,
    output logic [2:0]  neu_stack_index,
    output logic        neu_has_memory_op,
    output logic [1:0]  neu_operand_size,
    output logic        neu_is_integer,
    output logic        neu_is_bcd,
    output logic [79:0] neu_data,
    input  logic        neu_done,
    input  logic        neu_exception,
    output logic        busy,
    output logic        timeout_error,
    output logic [7:0]  issued_count
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        FLUSH
    } state_t;

    localparam bit          WD_ON   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] WD_LAST = WD_ON ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    state_t      state;
    logic [15:0] wd_count;
    logic        flush_opcode;
    logic        wd_expired;

    // The pop is gated by reset so the queue never loses an entry while we are held in reset.
    assign dequeue      = reset_n && (state == IDLE) && enable && !queue_empty;
    assign busy         = (state != IDLE);
    assign flush_opcode = (neu_instruction == OPC_FINIT) || (neu_instruction == OPC_FLDCW);
    assign wd_expired   = WD_ON && (wd_count == WD_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            wd_count          <= '0;
            flush_queue       <= 1'b0;
            neu_start         <= 1'b0;
            neu_instruction   <= '0;
            neu_stack_index   <= '0;
            neu_has_memory_op <= 1'b0;
            neu_operand_size  <= '0;
            neu_is_integer    <= 1'b0;
            neu_is_bcd        <= 1'b0;
            neu_data          <= '0;
            timeout_error     <= 1'b0;
            issued_count      <= '0;
        end else begin
            neu_start   <= 1'b0;
            flush_queue <= 1'b0;
            case (state)
                IDLE: begin
                    if (dequeue) begin
                        neu_instruction   <= instruction_in;
                        neu_stack_index   <= stack_index_in;
                        neu_has_memory_op <= has_memory_op_in;
                        neu_operand_size  <= operand_size_in;
                        neu_is_integer    <= is_integer_in;
                        neu_is_bcd        <= is_bcd_in;
                        neu_data          <= data_in;
                        issued_count      <= issued_count + 8'd1;
                        neu_start         <= 1'b1;
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd_count <= '0;
                    state    <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    wd_count <= wd_count + 16'd1;
                    // A done in the expiry cycle wins over the watchdog.
                    if (neu_done) begin
                        if (neu_exception || flush_opcode) begin
                            flush_queue <= 1'b1;
                            state       <= FLUSH;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (wd_expired) begin
                        timeout_error <= 1'b1;
                        flush_queue   <= 1'b1;
                        state         <= FLUSH;
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_queue_dispatcher.sv
// Scoreboard bench for fpu_queue_dispatcher: a queue model feeds the DUT, a NEU model answers
// each command, and expected commands/flushes/timing are derived from the abstract rules.
`timescale 1ns/1ps
module tb_fpu_queue_dispatcher;

    localparam int TO  = 6;
    localparam int BIG = 1 << 30;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        queue_empty;
    logic [7:0]  instruction_in;
    logic [2:0]  stack_index_in;
    logic        has_memory_op_in;
    logic [1:0]  operand_size_in;
    logic        is_integer_in;
    logic        is_bcd_in;
    logic [79:0] data_in;
    logic        dequeue;
    logic        flush_queue;
    logic        neu_start;
    logic [7:0]  neu_instruction;
    logic [2:0]  neu_stack_index;
    logic        neu_has_memory_op;
    logic [1:0]  neu_operand_size;
    logic        neu_is_integer;
    logic        neu_is_bcd;
    logic [79:0] neu_data;
    logic        neu_done;
    logic        neu_exception;
    logic        busy;
    logic        timeout_error;
    logic [7:0]  issued_count;

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  idx;
        logic        mem;
        logic [1:0]  sz;
        logic        isint;
        logic        isbcd;
        logic [79:0] data;
        int          delay;
        bit          exc;
    } entry_t;

    entry_t fifo[$];
    entry_t exp_cmd[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     free_cycle = 0;
    int     exp_flush_cycle = -1;
    int     deq_cycle = 0;
    bit     model_timeout = 1'b0;
    int     model_count = 0;

    fpu_queue_dispatcher #(
        .OPC_FINIT      (8'hF0),
        .OPC_FLDCW      (8'hF1),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .enable            (enable),
        .queue_empty       (queue_empty),
        .instruction_in    (instruction_in),
        .stack_index_in    (stack_index_in),
        .has_memory_op_in  (has_memory_op_in),
        .operand_size_in   (operand_size_in),
        .is_integer_in     (is_integer_in),
        .is_bcd_in         (is_bcd_in),
        .data_in           (data_in),
        .dequeue           (dequeue),
        .flush_queue       (flush_queue),
        .neu_start         (neu_start),
        .neu_instruction   (neu_instruction),
        .neu_stack_index   (neu_stack_index),
        .neu_has_memory_op (neu_has_memory_op),
        .neu_operand_size  (neu_operand_size),
        .neu_is_integer    (neu_is_integer),
        .neu_is_bcd        (neu_is_bcd),
        .neu_data          (neu_data),
        .neu_done          (neu_done),
        .neu_exception     (neu_exception),
        .busy              (busy),
        .timeout_error     (timeout_error),
        .issued_count      (issued_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic driveHead();
        if (fifo.size() > 0) begin
            queue_empty      = 1'b0;
            instruction_in   = fifo[0].op;
            stack_index_in   = fifo[0].idx;
            has_memory_op_in = fifo[0].mem;
            operand_size_in  = fifo[0].sz;
            is_integer_in    = fifo[0].isint;
            is_bcd_in        = fifo[0].isbcd;
            data_in          = fifo[0].data;
        end else begin
            queue_empty      = 1'b1;
            instruction_in   = '0;
            stack_index_in   = '0;
            has_memory_op_in = 1'b0;
            operand_size_in  = '0;
            is_integer_in    = 1'b0;
            is_bcd_in        = 1'b0;
            data_in          = '0;
        end
    endtask

    // delay = WAIT_DONE cycle (1-based) in which the NEU answers; 0 means it never answers.
    task automatic applyStimulus(input logic [7:0] op, input int delay, input bit exc);
        entry_t e;
        e.op    = op;
        e.idx   = 3'($urandom);
        e.mem   = 1'($urandom);
        e.sz    = 2'($urandom);
        e.isint = 1'($urandom);
        e.isbcd = 1'($urandom);
        e.data  = {16'($urandom), 32'($urandom), 32'($urandom)};
        e.delay = delay;
        e.exc   = exc;
        fifo.push_back(e);
        driveHead();
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (!(fifo.size() == 0 && exp_cmd.size() == 0 && cyc > free_cycle) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_idle: still busy after %0d cycles, expected idle", budget);
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_dequeue", dequeue, 0);
        checkOutput("rst_neu_start", neu_start, 0);
        checkOutput("rst_flush_queue", flush_queue, 0);
        checkOutput("rst_neu_instruction", neu_instruction, 0);
        checkOutput("rst_neu_stack_index", neu_stack_index, 0);
        checkOutput("rst_neu_has_memory_op", neu_has_memory_op, 0);
        checkOutput("rst_neu_operand_size", neu_operand_size, 0);
        checkOutput("rst_neu_is_integer", neu_is_integer, 0);
        checkOutput("rst_neu_is_bcd", neu_is_bcd, 0);
        checkOutput("rst_neu_data", neu_data, 0);
        checkOutput("rst_timeout_error", timeout_error, 0);
        checkOutput("rst_issued_count", issued_count, 0);
    endtask

    task automatic resetDut();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkResetOutputs();
        fifo.delete();
        exp_cmd.delete();
        driveHead();
        free_cycle      = 0;
        exp_flush_cycle = -1;
        model_timeout   = 1'b0;
        model_count     = 0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    // Queue model: checks per-cycle dequeue/busy/flush, then pops or flushes after the edge.
    initial begin
        bit deq;
        bit fl;
        forever begin
            @(negedge clk);
            deq = dequeue;
            fl  = flush_queue;
            checkOutput("dequeue", dequeue, reset_n && enable && fifo.size() > 0 && cyc >= free_cycle);
            checkOutput("busy", busy, reset_n && cyc < free_cycle);
            checkOutput("flush_queue", flush_queue, reset_n && cyc == exp_flush_cycle);
            @(posedge clk);
            #1;
            if (deq && fifo.size() > 0) begin
                exp_cmd.push_back(fifo.pop_front());
                model_count = (model_count + 1) % 256;
                free_cycle  = BIG;
                deq_cycle   = cyc - 1;
            end
            if (fl) fifo.delete();
            driveHead();
        end
    end

    // Monitor and NEU model: checks each command on neu_start and answers it.
    initial begin
        entry_t e;
        bit     done_seen;
        bit     aborted;
        bit     flush;
        neu_done      = 1'b0;
        neu_exception = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && neu_start) begin
                if (exp_cmd.size() == 0) begin
                    checkOutput("unexpected_start", 1, 0);
                    e = '{default: 0};
                end else begin
                    e = exp_cmd.pop_front();
                end
                checkOutput("neu_instruction", neu_instruction, e.op);
                checkOutput("neu_stack_index", neu_stack_index, e.idx);
                checkOutput("neu_has_memory_op", neu_has_memory_op, e.mem);
                checkOutput("neu_operand_size", neu_operand_size, e.sz);
                checkOutput("neu_is_integer", neu_is_integer, e.isint);
                checkOutput("neu_is_bcd", neu_is_bcd, e.isbcd);
                checkOutput("neu_data", neu_data, e.data);
                checkOutput("issued_count", issued_count, model_count);
                checkOutput("start_latency", cyc, deq_cycle + 1);
                checkOutput("timeout_error", timeout_error, model_timeout);
                neu_done      = 1'($urandom);
                neu_exception = 1'($urandom);
                done_seen     = 1'b0;
                aborted       = 1'b0;
                for (int k = 1; k <= TO && !done_seen && !aborted; k++) begin
                    @(posedge clk);
                    #1;
                    if (!reset_n) begin
                        aborted = 1'b1;
                    end else if (k == e.delay) begin
                        neu_done        = 1'b1;
                        neu_exception   = e.exc;
                        done_seen       = 1'b1;
                        flush           = e.exc || e.op == 8'hF0 || e.op == 8'hF1;
                        exp_flush_cycle = flush ? cyc + 1 : -1;
                        free_cycle      = flush ? cyc + 2 : cyc + 1;
                    end else begin
                        neu_done      = 1'b0;
                        neu_exception = 1'($urandom);
                        if (k == TO) begin
                            model_timeout   = 1'b1;
                            exp_flush_cycle = cyc + 1;
                            free_cycle      = cyc + 2;
                        end
                    end
                end
                if (!aborted) begin
                    @(posedge clk);
                    #1;
                    neu_done      = 1'b0;
                    neu_exception = 1'b0;
                    @(negedge clk);
                    if (reset_n) checkOutput("timeout_error_after", timeout_error, model_timeout);
                end else begin
                    neu_done      = 1'b0;
                    neu_exception = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        logic [7:0] op;
        int delay;
        reset_n = 1'b1;
        enable  = 1'b0;
        driveHead();
        #1 reset_n = 1'b0;
        #1 checkResetOutputs();

        // Entry waiting during reset must not be popped until release.
        applyStimulus(8'h12, 1, 1'b0);
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        waitIdle(50);
        checkOutput("issued_count_first", issued_count, 1);

        // FINIT flushes; the entry queued behind it is discarded.
        applyStimulus(8'hF0, 5, 1'b0);
        applyStimulus(8'h33, 1, 1'b0);
        waitIdle(50);
        checkOutput("issued_count_discard", issued_count, 2);

        applyStimulus(8'h20, 3, 1'b1);
        waitIdle(50);
        checkOutput("exception_no_timeout", timeout_error, 0);

        applyStimulus(8'hF1, 2, 1'b0);
        waitIdle(50);

        applyStimulus(8'h01, 1, 1'b0);
        applyStimulus(8'h02, 1, 1'b0);
        applyStimulus(8'h03, 2, 1'b0);
        waitIdle(50);

        enable = 1'b0;
        applyStimulus(8'h44, 1, 1'b0);
        applyStimulus(8'h45, 2, 1'b0);
        repeat (5) @(posedge clk);
        #2 enable = 1'b1;
        waitIdle(50);

        applyStimulus(8'h66, TO, 1'b0);
        waitIdle(50);
        checkOutput("timeout_boundary", timeout_error, 0);

        applyStimulus(8'h67, 0, 1'b0);
        waitIdle(50);
        checkOutput("timeout_sticky", timeout_error, 1);

        // Reset while the NEU is still working.
        applyStimulus(8'h55, 0, 1'b0);
        repeat (3) @(posedge clk);
        resetDut();
        applyStimulus(8'h12, 1, 1'b0);
        waitIdle(50);
        checkOutput("issued_after_reset", issued_count, 1);

        resetDut();
        for (int i = 0; i < 64; i++) begin
            for (int j = 0; j < 4; j++) applyStimulus(8'h40, 1, 1'b0);
            waitIdle(100);
        end
        checkOutput("issued_count_wrap", issued_count, 0);

        for (int i = 0; i < 80; i++) begin
            n = 1 + int'($urandom % 3);
            for (int j = 0; j < n; j++) begin
                op    = ($urandom % 6 == 0) ? (($urandom % 2 == 0) ? 8'hF0 : 8'hF1) : 8'($urandom);
                delay = ($urandom % 10 == 0) ? 0 : 1 + int'($urandom % TO);
                applyStimulus(op, delay, ($urandom % 8) == 0);
            end
            if ($urandom % 4 == 0) begin
                enable = 1'b0;
                repeat (1 + $urandom % 4) @(posedge clk);
                #2 enable = 1'b1;
            end
            waitIdle(200);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
